// File: rtl/maku_arb_pkg.sv
// Shared types and helpers for the MAKu UART TX arbiter.
package maku_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    localparam int STAT_W = 16;

    // Width of a requester index; never narrower than one bit.
    function automatic int idx_width(input int n);
        if (n <= 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/maku_rr_picker.sv
// Combinational round-robin picker: first set request at or after i_rr_ptr, wrapping.
module maku_rr_picker
    import maku_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_rr_ptr,
    output logic               o_found,
    output logic [IDX_W-1:0]   o_index
);

    int w_dist;
    int w_best;

    // Pick the requester whose circular distance from the pointer is smallest.
    always_comb begin
        o_found = 1'b0;
        o_index = '0;
        w_best  = NUM_REQ;
        w_dist  = 0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (j >= int'(i_rr_ptr)) begin
                w_dist = j - int'(i_rr_ptr);
            end else begin
                w_dist = j + NUM_REQ - int'(i_rr_ptr);
            end
            if (i_req[j] && (w_dist < w_best)) begin
                w_best  = w_dist;
                o_found = 1'b1;
                o_index = IDX_W'(j);
            end else begin
                w_best  = w_best;
            end
        end
    end

endmodule

// File: rtl/maku_uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART TX serializer among cores.
// Optional per-requester byte counters are built when MAKU_ARB_STATS_EN is defined.
module maku_uart_tx_arbiter
    import maku_arb_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]     req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          tx_valid,
    output logic [DATA_W-1:0]             tx_data,
    input  logic                          tx_ready,
    output logic [idx_width(NUM_REQ)-1:0] grant_id,
    output logic                          busy,
    output logic                          timeout_irq,
    output logic [NUM_REQ*STAT_W-1:0]     stat_bytes
);

    localparam int IDX_W = idx_width(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYC);

    arb_state_e          r_state;
    arb_state_e          w_next_state;
    logic [IDX_W-1:0]    r_grant_id;
    logic [IDX_W-1:0]    r_rr_ptr;
    logic [IDX_W-1:0]    w_rr_next;
    logic [IDX_W-1:0]    w_pick_index;
    logic                w_pick_found;
    logic [CNT_W-1:0]    r_stall_cnt;
    logic [CNT_W-1:0]    w_stall_next;
    logic                r_timeout_irq;
    logic                w_timeout;
    logic                w_release;
    logic                w_accept;
    logic                w_owner_valid;
    logic                w_owner_last;
    logic [DATA_W-1:0]   w_owner_data;
    logic                w_tx_valid;
    logic [DATA_W-1:0]   w_tx_data;
    logic [NUM_REQ-1:0]  w_req_ready;

    maku_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .i_req    (req_valid),
        .i_rr_ptr (r_rr_ptr),
        .o_found  (w_pick_found),
        .o_index  (w_pick_index)
    );

    // Mux the current owner's valid/last/byte out of the packed request buses.
    always_comb begin
        w_owner_valid = 1'b0;
        w_owner_last  = 1'b0;
        w_owner_data  = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            w_owner_valid = w_owner_valid | (req_valid[j] & (r_grant_id == IDX_W'(j)));
            w_owner_last  = w_owner_last  | (req_last[j]  & (r_grant_id == IDX_W'(j)));
            w_owner_data  = w_owner_data
                          | (req_data[j*DATA_W +: DATA_W] & {DATA_W{r_grant_id == IDX_W'(j)}});
        end
    end

    // Next state, combinational datapath while granted, and watchdog decision.
    always_comb begin
        w_next_state = r_state;
        w_tx_valid   = 1'b0;
        w_tx_data    = '0;
        w_req_ready  = '0;
        w_accept     = 1'b0;
        w_release    = 1'b0;
        w_timeout    = 1'b0;
        w_stall_next = '0;
        case (r_state)
            ARB_IDLE: begin
                if (w_pick_found) begin
                    w_next_state = ARB_GRANT;
                end else begin
                    w_next_state = ARB_IDLE;
                end
            end
            ARB_GRANT: begin
                w_tx_valid = w_owner_valid;
                w_tx_data  = w_owner_data;
                for (int j = 0; j < NUM_REQ; j++) begin
                    w_req_ready[j] = tx_ready & (r_grant_id == IDX_W'(j));
                end
                w_accept = w_owner_valid & tx_ready;
                // Only an absent owner ages the watchdog; backpressure keeps it at zero.
                if (w_accept) begin
                    w_release = w_owner_last;
                end else if (w_owner_valid) begin
                    w_stall_next = '0;
                end else if (r_stall_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                    w_release = 1'b1;
                    w_timeout = 1'b1;
                end else begin
                    w_stall_next = r_stall_cnt + CNT_W'(1);
                end
                if (w_release) begin
                    w_next_state = ARB_IDLE;
                end else begin
                    w_next_state = ARB_GRANT;
                end
            end
            default: begin
                w_next_state = ARB_IDLE;
            end
        endcase
    end

    // The released owner drops to lowest priority for the next arbitration.
    always_comb begin
        if (r_grant_id == IDX_W'(NUM_REQ - 1)) begin
            w_rr_next = '0;
        end else begin
            w_rr_next = r_grant_id + IDX_W'(1);
        end
    end

    // FSM state, owner, round-robin pointer, stall counter and irq pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ARB_IDLE;
            r_grant_id    <= '0;
            r_rr_ptr      <= '0;
            r_stall_cnt   <= '0;
            r_timeout_irq <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_stall_cnt   <= w_stall_next;
            r_timeout_irq <= w_timeout;
            if ((r_state == ARB_IDLE) && w_pick_found) begin
                r_grant_id <= w_pick_index;
            end else begin
                r_grant_id <= r_grant_id;
            end
            if (w_release) begin
                r_rr_ptr <= w_rr_next;
            end else begin
                r_rr_ptr <= r_rr_ptr;
            end
        end
    end

    assign tx_valid    = w_tx_valid;
    assign tx_data     = w_tx_data;
    assign req_ready   = w_req_ready;
    assign grant_id    = r_grant_id;
    assign busy        = (r_state == ARB_GRANT);
    assign timeout_irq = r_timeout_irq;

`ifdef MAKU_ARB_STATS_EN
    logic [STAT_W-1:0] r_stats [NUM_REQ];

    // Saturating accepted-byte counter per requester.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                r_stats[j] <= '0;
            end
        end else begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (w_accept && (r_grant_id == IDX_W'(j)) && (r_stats[j] != {STAT_W{1'b1}})) begin
                    r_stats[j] <= r_stats[j] + STAT_W'(1);
                end else begin
                    r_stats[j] <= r_stats[j];
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat_pack
        assign stat_bytes[g*STAT_W +: STAT_W] = r_stats[g];
    end
`else
    assign stat_bytes = '0;
`endif

endmodule

// File: tb/tb_maku_uart_tx_arbiter.sv
// Self-checking bench for maku_uart_tx_arbiter: directed scenarios plus randomized traffic vs. a packet-level model.
module tb_maku_uart_tx_arbiter;

    localparam int N  = 2;
    localparam int TO = 16;

    logic        clk;
    logic        rst_n;
    logic [1:0]  rv;
    logic [1:0]  rl;
    logic [15:0] rd;
    logic        tr;
    logic [1:0]  req_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic [0:0]  grant_id;
    logic        busy;
    logic        timeout_irq;
    logic [31:0] stat_bytes;

    maku_uart_tx_arbiter #(
        .NUM_REQ     (N),
        .DATA_W      (8),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (rv),
        .req_data    (rd),
        .req_last    (rl),
        .req_ready   (req_ready),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tr),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_irq (timeout_irq),
        .stat_bytes  (stat_bytes)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_err;

    // reference model state
    bit m_busy;
    bit m_irq;
    int m_owner;
    int m_ptr;
    int m_stall;
    int m_stat [2];

    // per-core packet sources ({last, byte}) and observed serializer stream
    logic [8:0] q0 [$];
    logic [8:0] q1 [$];
    bit         hold [2];
    int         hold_cnt [2];
    logic [7:0] log_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit vbit(input logic [1:0] v, input int i);
        return (i == 0) ? v[0] : v[1];
    endfunction

    function automatic logic [31:0] exp_stats();
`ifdef MAKU_ARB_STATS_EN
        return {m_stat[1][15:0], m_stat[0][15:0]};
`else
        return 32'h0;
`endif
    endfunction

    task automatic model_reset();
        m_busy  = 1'b0;
        m_irq   = 1'b0;
        m_owner = 0;
        m_ptr   = 0;
        m_stall = 0;
        m_stat[0] = 0;
        m_stat[1] = 0;
    endtask

    task automatic drive();
        rv[0]     = (q0.size() > 0) && !hold[0];
        rd[7:0]   = (q0.size() > 0) ? q0[0][7:0] : 8'h00;
        rl[0]     = (q0.size() > 0) ? q0[0][8] : 1'b0;
        rv[1]     = (q1.size() > 0) && !hold[1];
        rd[15:8]  = (q1.size() > 0) ? q1[0][7:0] : 8'h00;
        rl[1]     = (q1.size() > 0) ? q1[0][8] : 1'b0;
    endtask

    // Compare every output against the model, mid-cycle.
    task automatic sample();
        logic [7:0] e_data;
        logic [1:0] e_ready;
        #2;
        e_data  = m_busy ? ((m_owner == 0) ? rd[7:0] : rd[15:8]) : 8'h00;
        e_ready = (m_busy && tr) ? ((m_owner == 0) ? 2'b01 : 2'b10) : 2'b00;
        chk("busy",        32'(busy),        32'(m_busy));
        chk("grant_id",    32'(grant_id),    32'(m_owner));
        chk("tx_valid",    32'(tx_valid),    32'(m_busy && vbit(rv, m_owner)));
        chk("tx_data",     32'(tx_data),     32'(e_data));
        chk("req_ready",   32'(req_ready),   32'(e_ready));
        chk("timeout_irq", 32'(timeout_irq), 32'(m_irq));
        chk("stat_bytes",  stat_bytes,       exp_stats());
    endtask

    // Packet-level rules: arbitrate from the pointer, hold until last, reclaim after TO absent cycles.
    task automatic model_step();
        m_irq = 1'b0;
        if (!rst_n) begin
            model_reset();
        end else if (!m_busy) begin
            for (int k = 0; k < N; k++) begin
                if (!m_busy && vbit(rv, (m_ptr + k) % N)) begin
                    m_busy  = 1'b1;
                    m_owner = (m_ptr + k) % N;
                end
            end
            m_stall = 0;
        end else if (vbit(rv, m_owner) && tr) begin
            if (m_stat[m_owner] < 65535) m_stat[m_owner]++;
            m_stall = 0;
            if (vbit(rl, m_owner)) begin
                m_busy = 1'b0;
                m_ptr  = (m_owner + 1) % N;
            end
        end else if (vbit(rv, m_owner)) begin
            m_stall = 0;
        end else if (m_stall == TO - 1) begin
            m_busy  = 1'b0;
            m_ptr   = (m_owner + 1) % N;
            m_irq   = 1'b1;
            m_stall = 0;
        end else begin
            m_stall++;
        end
    endtask

    task automatic edge_();
        logic [1:0] pop;
        logic       took;
        logic [7:0] took_d;
        pop    = req_ready & rv;
        took   = tx_valid & tr;
        took_d = tx_data;
        @(posedge clk);
        #1;
        if (took) log_q.push_back(took_d);
        if (pop[0] && q0.size() > 0) void'(q0.pop_front());
        if (pop[1] && q1.size() > 0) void'(q1.pop_front());
        model_step();
        drive();
    endtask

    task automatic drain(input string tag, input int max_cyc);
        int n;
        n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || m_busy) && n < max_cyc) begin
            sample();
            edge_();
            n++;
        end
        chk(tag, 32'(q0.size() + q1.size()) + 32'(m_busy), 32'h0);
    endtask

    task automatic reset_mid();
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_busy",      32'(busy),        32'h0);
        chk("rst_tx_valid",  32'(tx_valid),    32'h0);
        chk("rst_tx_data",   32'(tx_data),     32'h0);
        chk("rst_req_ready", 32'(req_ready),   32'h0);
        chk("rst_grant_id",  32'(grant_id),    32'h0);
        chk("rst_irq",       32'(timeout_irq), 32'h0);
        chk("rst_stats",     stat_bytes,       32'h0);
        model_reset();
        q0.delete();
        q1.delete();
        log_q.delete();
        hold[0] = 1'b0; hold[1] = 1'b0;
        hold_cnt[0] = 0; hold_cnt[1] = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive();
    endtask

    task automatic push_pkt(input int core);
        int len;
        logic [8:0] e;
        len = $urandom_range(1, 4);
        for (int j = 0; j < len; j++) begin
            e = {(j == len - 1), 8'($urandom)};
            if (core == 0) q0.push_back(e);
            else q1.push_back(e);
        end
    endtask

    logic [7:0] exp_b [3];

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        tr    = 1'b0;
        hold[0] = 1'b0; hold[1] = 1'b0;
        hold_cnt[0] = 0; hold_cnt[1] = 0;
        model_reset();
        drive();
        repeat (2) @(posedge clk);
        #1;
        sample();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive();

        // single requester, three-byte packet
        exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33;
        q0.push_back({1'b0, 8'h11});
        q0.push_back({1'b0, 8'h22});
        q0.push_back({1'b1, 8'h33});
        tr = 1'b1;
        drive();
        sample();
        chk("single_arb_cycle_txv", 32'(tx_valid), 32'h0);
        edge_();
        for (int b = 0; b < 3; b++) begin
            sample();
            chk("single_byte", 32'(tx_data), 32'(exp_b[b]));
            chk("single_gid",  32'(grant_id), 32'h0);
            edge_();
        end
        sample();
        chk("single_done_busy", 32'(busy), 32'h0);
        edge_();

        // pointer now at 1: simultaneous one-byte requests go to core1 first
        q0.push_back({1'b1, 8'h80});
        q1.push_back({1'b1, 8'h90});
        log_q.delete();
        drive();
        drain("rr_drain", 20);
        chk("rr_first",  32'(log_q.size() > 0 ? log_q[0] : 8'h00), 32'h90);
        chk("rr_second", 32'(log_q.size() > 1 ? log_q[1] : 8'h00), 32'h80);

        // pointer back to 0 after a core1-only packet; contention with 2-byte packets
        q1.push_back({1'b1, 8'h44});
        drive();
        drain("ptr_drain", 20);
        log_q.delete();
        q0.push_back({1'b0, 8'hA0}); q0.push_back({1'b1, 8'hA1});
        q1.push_back({1'b0, 8'hB0}); q1.push_back({1'b1, 8'hB1});
        drive();
        drain("cont_drain", 30);
        chk("cont_len", 32'(log_q.size()), 32'd4);
        chk("cont_b0", 32'(log_q.size() > 0 ? log_q[0] : 8'h00), 32'hA0);
        chk("cont_b1", 32'(log_q.size() > 1 ? log_q[1] : 8'h00), 32'hA1);
        chk("cont_b2", 32'(log_q.size() > 2 ? log_q[2] : 8'h00), 32'hB0);
        chk("cont_b3", 32'(log_q.size() > 3 ? log_q[3] : 8'h00), 32'hB1);

        // long serializer backpressure never times out
        log_q.delete();
        q0.push_back({1'b0, 8'h5A}); q0.push_back({1'b1, 8'hA5});
        tr = 1'b0;
        drive();
        sample();
        edge_();
        for (int c = 0; c < 5000; c++) begin
            sample();
            chk("bp_data_held", 32'(tx_data), 32'h5A);
            edge_();
        end
        tr = 1'b1;
        drive();
        drain("bp_drain", 20);
        chk("bp_len", 32'(log_q.size()), 32'd2);
        chk("bp_b0", 32'(log_q.size() > 0 ? log_q[0] : 8'h00), 32'h5A);
        chk("bp_b1", 32'(log_q.size() > 1 ? log_q[1] : 8'h00), 32'hA5);

        // owner stalls after its first byte; watchdog hands the grant to waiting core1
        hold[1] = 1'b1;
        q1.push_back({1'b1, 8'h71});
        q0.push_back({1'b0, 8'h61}); q0.push_back({1'b1, 8'h62});
        drive();
        sample();
        edge_();
        sample();
        chk("stall_first", 32'(tx_data), 32'h61);
        edge_();
        hold[0] = 1'b1;
        hold[1] = 1'b0;
        drive();
        for (int k = 1; k <= TO; k++) begin
            sample();
            chk("stall_no_irq", 32'(timeout_irq), 32'h0);
            chk("stall_busy",   32'(busy),        32'h1);
            edge_();
        end
        sample();
        chk("stall_irq",      32'(timeout_irq), 32'h1);
        chk("stall_released", 32'(busy),        32'h0);
        edge_();
        sample();
        chk("stall_irq_pulse", 32'(timeout_irq), 32'h0);
        chk("stall_new_gid",   32'(grant_id),    32'h1);
        chk("stall_new_data",  32'(tx_data),     32'h71);
        edge_();
        hold[0] = 1'b0;
        drive();
        drain("stall_drain", 40);

        // randomized traffic with valid gaps, long stalls and a mid-run reset
        for (int it = 0; it < 3000; it++) begin
            if (it == 1500) reset_mid();
            if (q0.size() == 0 && $urandom_range(0, 3) == 0) push_pkt(0);
            if (q1.size() == 0 && $urandom_range(0, 3) == 0) push_pkt(1);
            for (int i = 0; i < 2; i++) begin
                if (hold_cnt[i] > 0) begin
                    hold_cnt[i]--;
                    hold[i] = 1'b1;
                end else if ($urandom_range(0, 99) == 0) begin
                    hold_cnt[i] = 20;
                    hold[i] = 1'b1;
                end else begin
                    hold[i] = ($urandom_range(0, 4) == 0);
                end
            end
            tr = ($urandom_range(0, 9) < 7);
            drive();
            sample();
            edge_();
        end
        hold[0] = 1'b0; hold[1] = 1'b0;
        hold_cnt[0] = 0; hold_cnt[1] = 0;
        tr = 1'b1;
        drive();
        drain("rand_drain", 200);

`ifdef MAKU_ARB_STATS_EN
        reset_mid();
        tr = 1'b1;
        for (int j = 0; j < 65540; j++) begin
            q1.push_back({(j == 65539), 8'(j)});
        end
        drive();
        drain("stats_drain", 70000);
        chk("stats_sat", stat_bytes, 32'hFFFF_0000);
`else
        chk("stats_off", stat_bytes, 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
